// File: rtl/lsu_dccm_bank_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dccm_pkg
//  Purpose  : Shared DCCM geometry constants, read-pipeline entry type and
//             the byte-address to bank decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_dccm_pkg;

   // Bank geometry of this DCCM configuration; the arbiter and the
   // interface take their parameter defaults from here.
   localparam int DCCM_NUM_BANKS  = 4;
   localparam int DCCM_DATA_WIDTH = 32;
   localparam int DCCM_ECC_WIDTH  = 7;
   localparam int DCCM_ADDR_WIDTH = 16;

   localparam int BYTE_BITS   = $clog2(DCCM_DATA_WIDTH / 8);
   localparam int BANK_BITS   = $clog2(DCCM_NUM_BANKS);
   localparam int FDATA_WIDTH = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;

   typedef logic [BANK_BITS-1:0] bank_t;

   // One in-flight read: which banks feed lo/hi and whether they coincide.
   typedef struct packed {
      logic  valid;
      bank_t bl;
      bank_t bh;
      logic  same;
   } rd_pipe_t;

   // Bank index sits just above the byte-in-word offset; truncation after
   // the shift gives the modulo wrap (bank 3 -> bank 0) for free.
   function automatic bank_t bank_of(input logic [DCCM_ADDR_WIDTH-1:0] addr);
      return bank_t'(addr >> BYTE_BITS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dccm_bank_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dccm_bank_arb_if
//  Purpose  : LSU request/response and DCCM bank bus bundle for the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_dccm_bank_arb_if
   import lsu_dccm_pkg::*;
#(
   parameter int NUM_BANKS  = DCCM_NUM_BANKS,
   parameter int DATA_WIDTH = DCCM_DATA_WIDTH,
   parameter int ECC_WIDTH  = DCCM_ECC_WIDTH,
   parameter int ADDR_WIDTH = DCCM_ADDR_WIDTH
);
   localparam int FW = DATA_WIDTH + ECC_WIDTH;

   logic                      freeze;
   logic                      ld_valid;
   logic [ADDR_WIDTH-1:0]     ld_addr_lo;
   logic [ADDR_WIDTH-1:0]     ld_addr_hi;
   logic                      ld_ready;
   logic                      st_valid;
   logic [ADDR_WIDTH-1:0]     st_addr;
   logic [FW-1:0]             st_data;
   logic                      st_ready;
   logic                      st_forced;
   logic [NUM_BANKS-1:0]      bank_rden;
   logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_rd_addr;
   logic [NUM_BANKS-1:0]      bank_wren;
   logic [ADDR_WIDTH-1:0]     bank_wr_addr;
   logic [FW-1:0]             bank_wr_data;
   logic [NUM_BANKS*FW-1:0]   bank_rd_data;
   logic                      ld_rvalid;
   logic [FW-1:0]             ld_rdata_lo;
   logic [FW-1:0]             ld_rdata_hi;

   // Arbiter side
   modport slave (
      input  freeze, ld_valid, ld_addr_lo, ld_addr_hi, st_valid, st_addr,
             st_data, bank_rd_data,
      output ld_ready, st_ready, st_forced, bank_rden, bank_rd_addr,
             bank_wren, bank_wr_addr, bank_wr_data, ld_rvalid,
             ld_rdata_lo, ld_rdata_hi
   );

   // LSU / SRAM side
   modport master (
      output freeze, ld_valid, ld_addr_lo, ld_addr_hi, st_valid, st_addr,
             st_data, bank_rd_data,
      input  ld_ready, st_ready, st_forced, bank_rden, bank_rd_addr,
             bank_wren, bank_wr_addr, bank_wr_data, ld_rvalid,
             ld_rdata_lo, ld_rdata_hi
   );
endinterface
`default_nettype wire

// File: rtl/lsu_dccm_bank_arb_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dccm_rd_pipe
//  Purpose  : RD_LAT-deep delay line tracking in-flight reads, then bank
//             steering of SRAM data into registered lo/hi load words.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_dccm_rd_pipe
   import lsu_dccm_pkg::*;
#(
   parameter int NUM_BANKS = DCCM_NUM_BANKS,
   parameter int FW        = FDATA_WIDTH,
   parameter int RD_LAT    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  rd_pipe_t                entry_in,
   input  logic [NUM_BANKS*FW-1:0] bank_rd_data,
   output logic                    rvalid,
   output logic [FW-1:0]           rdata_lo,
   output logic [FW-1:0]           rdata_hi
);
   rd_pipe_t      pipe_q [RD_LAT];
   rd_pipe_t      pipe_d [RD_LAT];
   rd_pipe_t      last;
   logic [FW-1:0] sel_lo, sel_hi;
   logic          rvalid_q, rvalid_d;
   logic [FW-1:0] rdata_lo_q, rdata_lo_d;
   logic [FW-1:0] rdata_hi_q, rdata_hi_d;

   // Shift the tracking entries; the SRAM never stalls so neither do we.
   // The oldest entry picks its banks' words, which are captured only when
   // that entry carries a real read so the outputs hold otherwise.
   always_comb begin
      pipe_d[0] = entry_in;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      last       = pipe_q[RD_LAT-1];
      sel_lo     = bank_rd_data[int'(last.bl)*FW +: FW];
      sel_hi     = last.same ? sel_lo : bank_rd_data[int'(last.bh)*FW +: FW];
      rvalid_d   = last.valid;
      rdata_lo_d = last.valid ? sel_lo : rdata_lo_q;
      rdata_hi_d = last.valid ? sel_hi : rdata_hi_q;
   end

   // Pipeline and output registers; reset drops every in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
         rvalid_q   <= 1'b0;
         rdata_lo_q <= '0;
         rdata_hi_q <= '0;
      end else begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         rvalid_q   <= rvalid_d;
         rdata_lo_q <= rdata_lo_d;
         rdata_hi_q <= rdata_hi_d;
      end
   end

   assign rvalid   = rvalid_q;
   assign rdata_lo = rdata_lo_q;
   assign rdata_hi = rdata_hi_q;
endmodule
`default_nettype wire

// File: rtl/lsu_dccm_bank_arb.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dccm_bank_arb
//  Purpose  : DCCM port arbiter - one load (lo/hi bank pair) against one
//             store-buffer drain per cycle, with anti-starvation forcing of
//             the store and a configurable-latency read return path.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_dccm_bank_arb
   import lsu_dccm_pkg::*;
#(
   parameter int NUM_BANKS  = DCCM_NUM_BANKS,
   parameter int DATA_WIDTH = DCCM_DATA_WIDTH,
   parameter int ECC_WIDTH  = DCCM_ECC_WIDTH,
   parameter int ADDR_WIDTH = DCCM_ADDR_WIDTH,
   parameter int RD_LAT     = 1,
   parameter int STALL_MAX  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   lsu_dccm_bank_arb_if.slave   bus
);
   localparam int FW    = DATA_WIDTH + ECC_WIDTH;
   localparam int CNT_W = $clog2(STALL_MAX + 1);

   bank_t            bl, bh, bs;
   logic             conf, force_pri, ld_gnt, st_gnt;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   rd_pipe_t         rd_entry;

   // Decode banks and decide grants: the load wins a conflict unless the
   // store has waited long enough to be forced through.
   always_comb begin
      bl        = bank_of(bus.ld_addr_lo);
      bh        = bank_of(bus.ld_addr_hi);
      bs        = bank_of(bus.st_addr);
      conf      = bus.ld_valid & ((bs == bl) | (bs == bh));
      force_pri = (stall_cnt_q == CNT_W'(STALL_MAX));
      ld_gnt    = bus.ld_valid & ~bus.freeze & ~(force_pri & bus.st_valid & conf);
      st_gnt    = bus.st_valid & ~bus.freeze & (~ld_gnt | ~conf);
      rd_entry  = '{valid: ld_gnt, bl: bl, bh: bh, same: (bl == bh)};
   end

   // Drive the bank read/write ports from the grants.
   always_comb begin
      bus.bank_rden    = '0;
      bus.bank_rd_addr = '0;
      bus.bank_wren    = '0;
      if (ld_gnt) begin
         bus.bank_rden[bl]                                = 1'b1;
         bus.bank_rd_addr[int'(bl)*ADDR_WIDTH +: ADDR_WIDTH] = bus.ld_addr_lo;
         if (bh != bl) begin
            bus.bank_rden[bh]                                = 1'b1;
            bus.bank_rd_addr[int'(bh)*ADDR_WIDTH +: ADDR_WIDTH] = bus.ld_addr_hi;
         end
      end
      if (st_gnt) begin
         bus.bank_wren[bs] = 1'b1;
      end
      bus.bank_wr_addr = bus.st_addr;
      bus.bank_wr_data = bus.st_data;
      bus.ld_ready     = ld_gnt;
      bus.st_ready     = st_gnt;
      bus.st_forced    = st_gnt & force_pri & conf;
   end

   // Count consecutive cycles a pending store is refused; freeze pauses it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (~bus.st_valid | st_gnt) begin
         stall_cnt_d = '0;
      end else if (~bus.freeze && stall_cnt_q != CNT_W'(STALL_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   lsu_dccm_rd_pipe #(
      .NUM_BANKS (NUM_BANKS),
      .FW        (FW),
      .RD_LAT    (RD_LAT)
   ) u_rd_pipe (
      .clk          (clk),
      .rst          (rst),
      .entry_in     (rd_entry),
      .bank_rd_data (bus.bank_rd_data),
      .rvalid       (bus.ld_rvalid),
      .rdata_lo     (bus.ld_rdata_lo),
      .rdata_hi     (bus.ld_rdata_hi)
   );
endmodule
`default_nettype wire
